// File: rtl/fs_accel_bpfifo_pkg.sv
// fs_accel_bpfifo_pkg: shared defaults and mode encodings for the bypass FIFO
package fs_accel_bpfifo_pkg;
    localparam int   FS_ACCEL_DW      = 32;
    localparam int   FS_ACCEL_BPDEPTH = 4;
    localparam logic FS_BP_MODE_FIFO  = 1'b0;
    localparam logic FS_BP_MODE_HOLD  = 1'b1;
endpackage

// File: rtl/fs_accel_ptr_ctr.sv
// fs_accel_ptr_ctr: wrap-around pointer with increment and synchronous clear
module fs_accel_ptr_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fs_accel_bpfifo.sv
// fs_accel_bpfifo: FWFT bypass FIFO with legacy hold-register mode and sticky error flags
module fs_accel_bpfifo
    import fs_accel_bpfifo_pkg::*;
#(
    parameter int DATA_W = FS_ACCEL_DW,
    parameter int DEPTH  = FS_ACCEL_BPDEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enb,
    input  logic              clr,
    input  logic              mode,
    input  logic [DATA_W-1:0] bpbuf_di,
    input  logic              bpbuf_ld_wrn,
    input  logic              bpbuf_rd,
    output logic [DATA_W-1:0] bpbuf_do,
    output logic              bpbuf_empty,
    output logic              bpbuf_full,
    output logic [CNT_W-1:0]  bpbuf_cnt,
    output logic              bpbuf_ovf,
    output logic              bpbuf_udf
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              act, fifo, push_req, pop_req, push, pop, hold_ld;

    assign act      = enb && !clr;
    assign fifo     = act && mode != FS_BP_MODE_HOLD;
    assign push_req = fifo && bpbuf_ld_wrn;
    assign pop_req  = fifo && bpbuf_rd;
    assign pop      = pop_req && !bpbuf_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push     = push_req && (!bpbuf_full || pop);
    assign hold_ld  = act && mode == FS_BP_MODE_HOLD && bpbuf_ld_wrn;

    fs_accel_ptr_ctr #(.W(PW)) u_wr (.clk(clk), .resetn(resetn), .clr(clr), .inc(push), .ptr(wr_ptr));
    fs_accel_ptr_ctr #(.W(PW)) u_rd (.clk(clk), .resetn(resetn), .clr(clr), .inc(pop), .ptr(rd_ptr));

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) mem <= '{default: '0};
        else if (push) mem[wr_ptr] <= bpbuf_di;
        else if (hold_ld) mem[rd_ptr] <= bpbuf_di;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            bpbuf_cnt <= '0;
            bpbuf_ovf <= 1'b0;
            bpbuf_udf <= 1'b0;
        end else if (clr) begin
            bpbuf_cnt <= '0;
            bpbuf_ovf <= 1'b0;
            bpbuf_udf <= 1'b0;
        end else begin
            if (push != pop) bpbuf_cnt <= push ? bpbuf_cnt + 1'b1 : bpbuf_cnt - 1'b1;
            if (push_req && bpbuf_full && !pop) bpbuf_ovf <= 1'b1;
            if (pop_req && bpbuf_empty) bpbuf_udf <= 1'b1;
        end

    assign bpbuf_do    = mem[rd_ptr];
    assign bpbuf_empty = bpbuf_cnt == '0;
    assign bpbuf_full  = bpbuf_cnt == CNT_W'(DEPTH);
endmodule

// File: tb/tb_fs_accel_bpfifo.sv
// tb_fs_accel_bpfifo: directed vector table, async-reset sequence and random run against a queue model
module tb_fs_accel_bpfifo;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 0, resetn = 0, enb = 0, clr = 0, mode = 0, ld = 0, rd = 0;
    logic [DW-1:0] di = '0, dout;
    logic          empty, full, ovf, udf;
    logic [2:0]    cnt;
    int            checks = 0, errors = 0;

    fs_accel_bpfifo dut (
        .clk(clk), .resetn(resetn), .enb(enb), .clr(clr), .mode(mode),
        .bpbuf_di(di), .bpbuf_ld_wrn(ld), .bpbuf_rd(rd), .bpbuf_do(dout),
        .bpbuf_empty(empty), .bpbuf_full(full), .bpbuf_cnt(cnt),
        .bpbuf_ovf(ovf), .bpbuf_udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en, cl, md, l, r;
        logic [DW-1:0] d, e_do;
        logic e_em, e_fu, e_ov, e_ud;
        logic [2:0] e_cnt;
    } vec_t;
    vec_t vq[$];

    task automatic add(input int en, cl, md, l, r, input logic [DW-1:0] d, e_do,
                       input int em, fu, c, ov, ud);
        vec_t v;
        v.en = en != 0; v.cl = cl != 0; v.md = md != 0; v.l = l != 0; v.r = r != 0;
        v.d = d; v.e_do = e_do;
        v.e_em = em != 0; v.e_fu = fu != 0; v.e_cnt = 3'(c); v.e_ov = ov != 0; v.e_ud = ud != 0;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, cl, md, l, r, input logic [DW-1:0] d);
        enb = en; clr = cl; mode = md; ld = l; rd = r; di = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        enb = 0; clr = 0; mode = 0; ld = 0; rd = 0;
        @(negedge clk);
        resetn = 1;
    endtask

    logic [DW-1:0] q[$];
    logic          m_ov, m_ud;

    initial begin
        // {en,clr,mode,ld,rd,di} -> {do,empty,full,cnt,ovf,udf}
        add(1,0,0,1,0,'h11, 'h11,0,0,1,0,0);
        add(1,0,0,1,0,'h22, 'h11,0,0,2,0,0);
        add(1,0,0,1,0,'h33, 'h11,0,0,3,0,0);
        add(1,0,0,1,0,'h44, 'h11,0,1,4,0,0);
        add(1,0,0,1,0,'h55, 'h11,0,1,4,1,0);
        add(1,0,0,0,1,'h0,  'h22,0,0,3,1,0);
        add(1,0,0,0,1,'h0,  'h33,0,0,2,1,0);
        add(1,0,0,0,1,'h0,  'h44,0,0,1,1,0);
        add(1,0,0,0,1,'h0,  'h11,1,0,0,1,0);
        add(1,0,0,0,1,'h0,  'h11,1,0,0,1,1);
        add(1,1,0,1,1,'h99, 'h11,1,0,0,0,0);
        add(1,0,0,1,0,'h11, 'h11,0,0,1,0,0);
        add(1,0,0,1,0,'h22, 'h11,0,0,2,0,0);
        add(1,0,0,1,0,'h33, 'h11,0,0,3,0,0);
        add(1,0,0,1,0,'h44, 'h11,0,1,4,0,0);
        add(1,0,0,1,1,'h55, 'h22,0,1,4,0,0);
        add(1,0,0,0,1,'h0,  'h33,0,0,3,0,0);
        add(1,0,0,0,1,'h0,  'h44,0,0,2,0,0);
        add(1,0,0,0,1,'h0,  'h55,0,0,1,0,0);
        add(1,0,0,0,1,'h0,  'h22,1,0,0,0,0);
        add(1,0,0,1,1,'h77, 'h77,0,0,1,0,1);
        add(1,1,0,0,0,'h0,  'h55,1,0,0,0,0);
        add(1,0,1,1,0,'hDEADBEEF, 'hDEADBEEF,1,0,0,0,0);
        add(1,0,1,0,1,'h0,  'hDEADBEEF,1,0,0,0,0);
        add(1,0,1,0,1,'h0,  'hDEADBEEF,1,0,0,0,0);
        add(1,0,1,0,1,'h0,  'hDEADBEEF,1,0,0,0,0);
        add(1,0,1,1,0,'h12345678, 'h12345678,1,0,0,0,0);
        add(0,0,0,1,0,'hAA, 'h12345678,1,0,0,0,0);
        add(0,0,0,0,1,'hAB, 'h12345678,1,0,0,0,0);
        add(0,0,0,1,1,'hAC, 'h12345678,1,0,0,0,0);
        add(1,0,0,1,0,'h01, 'h01,0,0,1,0,0);
        add(1,0,0,1,0,'h02, 'h01,0,0,2,0,0);
        add(1,0,0,1,0,'h03, 'h01,0,0,3,0,0);
        add(1,0,0,1,0,'h04, 'h01,0,1,4,0,0);
        add(1,0,0,1,0,'h05, 'h01,0,1,4,1,0);
        add(0,1,0,1,1,'h06, 'h01,1,0,0,0,0);

        // reset state
        @(negedge clk);
        chk("rst_do", 64'(dout), 0);
        chk("rst_flags", {empty, full, ovf, udf}, 4'b1000);
        chk("rst_cnt", 64'(cnt), 0);
        resetn = 1;

        // asynchronous reset mid-stream
        drive(1,0,0,1,0,'hA1);
        drive(1,0,0,1,0,'hA2);
        chk("pre_rst_cnt", 64'(cnt), 2);
        @(posedge clk);
        #2 resetn = 0;
        #1;
        chk("async_do", 64'(dout), 0);
        chk("async_empty", 64'(empty), 1);
        chk("async_cnt", 64'(cnt), 0);
        @(negedge clk);
        resetn = 1;
        enb = 0; ld = 0;

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].cl, vq[i].md, vq[i].l, vq[i].r, vq[i].d);
            chk($sformatf("vec%0d_do", i), 64'(dout), 64'(vq[i].e_do));
            chk($sformatf("vec%0d_st", i), {empty, full, cnt, ovf, udf},
                {vq[i].e_em, vq[i].e_fu, vq[i].e_cnt, vq[i].e_ov, vq[i].e_ud});
        end

        // random run against a queue model
        do_reset();
        q.delete(); m_ov = 0; m_ud = 0;
        for (int n = 0; n < 3000; n++) begin
            logic en, cl, md, l, r, pop_ok, push_ok;
            logic [DW-1:0] d;
            en = $urandom_range(0, 9) != 0;
            cl = $urandom_range(0, 49) == 0;
            md = $urandom_range(0, 4) == 0;
            l  = $urandom_range(0, 1) == 1;
            r  = $urandom_range(0, 1) == 1;
            d  = $urandom;
            if (cl) begin
                q.delete(); m_ov = 0; m_ud = 0;
            end else if (en && !md) begin
                pop_ok  = r && q.size() > 0;
                push_ok = l && (q.size() < D || pop_ok);
                if (r && q.size() == 0) m_ud = 1;
                if (l && !push_ok) m_ov = 1;
                if (pop_ok) void'(q.pop_front());
                if (push_ok) q.push_back(d);
            end else if (en && l && q.size() > 0) q[0] = d;
            drive(en, cl, md, l, r, d);
            chk("rnd_st", {empty, full, cnt, ovf, udf},
                {q.size() == 0, q.size() == D, 3'(q.size()), m_ov, m_ud});
            if (q.size() > 0) chk("rnd_do", 64'(dout), 64'(q[0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
